serializador_paralelo_serial: RTL

Parallel-in/serial-out transmitter: the sending end for the team's 4-bit serial-in shift register.
- Accepts an NBITS word over a valid/ready handshake.
- Shifts the word out LSB-first, one bit per clk_2 cycle. Shift order is chosen so a shift-right receiver (serial in at MSB, moving toward bit 0) holds the original word after NBITS shifts.
- A one-entry pending buffer allows back-to-back frames with no idle gap.
- Sits beside the receiver in top; driven from SWI, observed on LED.

---
 rtl/serializador_paralelo_serial_pkg.sv | 12 +
 rtl/serializador_paralelo_serial_contador_bits.sv | 38 +++
 rtl/serializador_paralelo_serial.sv | 109 ++++++++++
 3 files changed

// File: rtl/serializador_paralelo_serial_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
// Default word width and FSM state encoding.
package serializador_paralelo_serial_pkg;

  localparam int NBITS_SERIAL = 4;

  typedef enum logic {
    OCIOSO,
    DESLOCANDO
  } estado_ser_t;

endpackage

// File: rtl/serializador_paralelo_serial_contador_bits.sv
// Modulo-NBITS bit counter with synchronous clear and enable.
// ult_o flags the terminal count (NBITS-1).
module contador_bits #(
  parameter int NBITS = 4,
  parameter int CW    = $clog2(NBITS)
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          ult_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign ult_o = (cnt_q == CW'(NBITS - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = ult_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serializador_paralelo_serial.sv
// Parallel-in/serial-out transmitter: LSB-first frames over a valid/ready
// handshake, with a one-entry pending buffer for gapless back-to-back frames.
module serializador_paralelo_serial
  import serializador_paralelo_serial_pkg::*;
#(
  parameter int NBITS = NBITS_SERIAL
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] ent_paralela,
  input  logic             ent_valida,
  output logic             pronto,
  output logic             saida_serial,
  output logic             saida_valida,
  output logic             fim,
  output logic             ocupado
);

  localparam int CW = $clog2(NBITS);

  estado_ser_t      estado_q, estado_d;
  logic [NBITS-1:0] desloc_q, desloc_d;
  logic [NBITS-1:0] pendente_q, pendente_d;
  logic             pendCheio_q, pendCheio_d;

  logic [CW-1:0]    contador;
  logic             ult;
  logic             cntClr;
  logic             cntEn;
  logic             aceita;

  contador_bits #(
    .NBITS (NBITS),
    .CW    (CW)
  ) u_contador_bits (
    .clk_2 (clk_2),
    .reset (reset),
    .clr_i (cntClr),
    .en_i  (cntEn),
    .cnt_o (contador),
    .ult_o (ult)
  );

  // pronto depends only on registered state and reset, never on ent_valida.
  assign pronto       = !pendCheio_q && !reset;
  assign aceita       = ent_valida && pronto;
  assign saida_valida = (estado_q == DESLOCANDO) && !reset;
  assign saida_serial = saida_valida && desloc_q[0];
  assign fim          = saida_valida && (contador == CW'(NBITS - 1));
  assign ocupado      = ((estado_q == DESLOCANDO) || pendCheio_q) && !reset;

  always_comb begin
    estado_d    = estado_q;
    desloc_d    = desloc_q;
    pendente_d  = pendente_q;
    pendCheio_d = pendCheio_q;
    cntClr      = 1'b0;
    cntEn       = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          desloc_d = ent_paralela;
          cntClr   = 1'b1;
          estado_d = DESLOCANDO;
        end
      end

      DESLOCANDO: begin
        cntEn    = 1'b1;
        desloc_d = desloc_q >> 1;
        if (ult) begin
          // Pending word wins over a fresh accept; pronto is low then anyway.
          cntClr = 1'b1;
          if (pendCheio_q) begin
            desloc_d    = pendente_q;
            pendCheio_d = 1'b0;
          end else if (aceita) begin
            desloc_d = ent_paralela;
          end else begin
            estado_d = OCIOSO;
          end
        end else if (aceita) begin
          pendente_d  = ent_paralela;
          pendCheio_d = 1'b1;
        end
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      desloc_q    <= '0;
      pendente_q  <= '0;
      pendCheio_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      desloc_q    <= desloc_d;
      pendente_q  <= pendente_d;
      pendCheio_q <= pendCheio_d;
    end
  end

endmodule
